adc_capture_ctrl: RTL

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

---
 rtl/adc_capture_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: packs PACK beats per word into a show-ahead buffer, with arm/trigger/drain FSM.
// Optional build macro ADC_CAPTURE_TEST_PATTERN_EN replaces adc_data with an incrementing test pattern.
module adc_capture_ctrl #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SAMPLE_W    = 12,
    parameter int unsigned PACK        = 8,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned READY_LEVEL = 128,
    parameter int unsigned END_LEVEL   = 0,
    parameter int unsigned FRAME_W     = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 adc_valid,
    input  logic [CHANNELS*SAMPLE_W-1:0]         adc_data,
    input  logic                                 start,
    input  logic                                 abort,
    input  logic                                 trig_en,
    input  logic                                 trig,
    input  logic [FRAME_W-1:0]                   frame_len,
    input  logic                                 rd_ready,
    output logic                                 rd_valid,
    output logic [CHANNELS*SAMPLE_W*PACK-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]               level,
    output logic                                 rdy,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 ovf,
    output logic [15:0]                          ovf_cnt
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned LW     = AW + 1;
    localparam int unsigned BEAT_W = CHANNELS * SAMPLE_W;
    localparam int unsigned WORD_W = BEAT_W * PACK;
    localparam int unsigned PCW    = (PACK > 1) ? $clog2(PACK) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t              state, state_nxt;
    logic                done_nxt;

    logic [WORD_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level_q, level_nxt;
    logic                rdy_q, rdy_nxt;
    logic                done_q;
    logic                ovf_q;
    logic [15:0]         ovf_cnt_q;

    logic [PCW-1:0]      pack_cnt;
    logic [WORD_W-1:0]   pack_buf, word_nxt;
    logic [FRAME_W-1:0]  frame_len_q, word_cnt, word_cnt_inc;
    logic [BEAT_W-1:0]   beat_data;

    logic start_ok, beat_ok, word_done, full, pop, wr_en, frame_end;

    assign start_ok     = (state == S_IDLE) && start && !abort && (frame_len != '0);
    assign beat_ok      = (state == S_CAPTURE) && adc_valid && !abort;
    assign word_done    = beat_ok && (pack_cnt == PCW'(PACK - 1));
    assign full         = (level_q == LW'(DEPTH));
    assign pop          = (level_q != '0) && rd_ready;
    assign wr_en        = word_done && !full;
    assign word_cnt_inc = word_cnt + FRAME_W'(1);
    // Dropped words still count toward the frame so a stalled consumer cannot stretch a capture.
    assign frame_end    = word_done && (word_cnt_inc == frame_len_q);

`ifdef ADC_CAPTURE_TEST_PATTERN_EN
    logic [SAMPLE_W-1:0] pat;

    always_ff @(posedge clk) begin
        if (rst) begin
            pat <= '0;
        end else if (start_ok) begin
            pat <= '0;
        end else if (beat_ok) begin
            pat <= pat + SAMPLE_W'(1);
        end
    end

    always_comb begin
        beat_data = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            beat_data[c*SAMPLE_W +: SAMPLE_W] = pat + SAMPLE_W'(c);
        end
    end
`else
    always_comb begin
        beat_data = adc_data;
    end
`endif

    // The completing beat is merged combinationally so the word lands in RAM on the same edge.
    always_comb begin
        word_nxt = pack_buf;
        word_nxt[int'(pack_cnt)*BEAT_W +: BEAT_W] = beat_data;
    end

    always_comb begin
        level_nxt = level_q;
        if (wr_en && !pop) begin
            level_nxt = level_q + LW'(1);
        end else if (!wr_en && pop) begin
            level_nxt = level_q - LW'(1);
        end
    end

    always_comb begin
        rdy_nxt = rdy_q;
        if (level_nxt >= LW'(READY_LEVEL)) begin
            rdy_nxt = 1'b1;
        end else if (rdy_q && (level_nxt <= LW'(END_LEVEL))) begin
            rdy_nxt = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    if (start_ok) state_nxt = S_ARMED;
                S_ARMED:   if (!trig_en || trig) state_nxt = S_CAPTURE;
                S_CAPTURE: if (frame_end) state_nxt = S_DRAIN;
                S_DRAIN: begin
                    if (level_q == '0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            done_q      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            rdy_q       <= 1'b0;
            pack_cnt    <= '0;
            frame_len_q <= '0;
            word_cnt    <= '0;
            ovf_q       <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (abort) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level_q  <= '0;
                rdy_q    <= 1'b0;
                pack_cnt <= '0;
            end else begin
                if (wr_en) wr_ptr <= wr_ptr + AW'(1);
                if (pop)   rd_ptr <= rd_ptr + AW'(1);
                level_q <= level_nxt;
                rdy_q   <= rdy_nxt;
                if (start_ok) begin
                    frame_len_q <= frame_len;
                    word_cnt    <= '0;
                    pack_cnt    <= '0;
                    ovf_q       <= 1'b0;
                    ovf_cnt_q   <= '0;
                end
                if (beat_ok) begin
                    pack_buf <= word_nxt;
                    pack_cnt <= word_done ? '0 : pack_cnt + PCW'(1);
                    if (word_done) word_cnt <= word_cnt_inc;
                end
                if (word_done && full) begin
                    ovf_q <= 1'b1;
                    if (ovf_cnt_q != '1) ovf_cnt_q <= ovf_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= word_nxt;
        end
    end

    assign rd_valid = (level_q != '0);
    assign rd_data  = mem[rd_ptr];
    assign level    = level_q;
    assign rdy      = rdy_q;
    assign busy     = (state != S_IDLE);
    assign done     = done_q;
    assign ovf      = ovf_q;
    assign ovf_cnt  = ovf_cnt_q;

endmodule
